// File: rtl/fib_pkg.sv
// Shared widths and FSM state encoding for the Fibonacci engine.
package fib_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fib_core.sv
// Iterative a/b/cnt datapath for F(n); the FIB_SATURATE_EN macro adds sticky
// overflow tracking that forces the result to all-ones.
module fib_core
    import fib_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [IN_W-1:0]  n,
    output logic             cnt_zero,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0] a_q, a_d, b_q, b_d, sum;
    logic [IN_W-1:0]  cnt_q, cnt_d;

`ifdef FIB_SATURATE_EN
    // One flag per register: b runs one term ahead of a, so an overflow in b
    // only poisons the result once it has shifted into a.
    logic [OUT_W:0] sum_ext;
    logic           a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;

    assign sum_ext = {1'b0, a_q} + {1'b0, b_q};
    assign sum     = sum_ext[OUT_W-1:0];
    assign result  = a_ovf_q ? {OUT_W{1'b1}} : a_q;

    always_comb begin
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        if (load) begin
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
        end else if (step) begin
            a_ovf_d = b_ovf_q;
            b_ovf_d = b_ovf_q | a_ovf_q | sum_ext[OUT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
        end else begin
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
        end
    end
`else
    assign sum    = a_q + b_q;
    assign result = a_q;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (load) begin
            a_d   = '0;
            b_d   = OUT_W'(1);
            cnt_d = n;
        end else if (step) begin
            a_d   = b_q;
            b_d   = sum;
            cnt_d = cnt_q - IN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fib.sv
// Fibonacci engine top: request/result handshakes and sequencing FSM.
// Build with FIB_SATURATE_EN to saturate on overflow instead of wrapping.
//   state | meaning
//   IDLE  | waiting for a request, rdy_in=1
//   CALC  | iterating the datapath until cnt reaches zero
//   DONE  | result valid, holding until rdy_out
module fib
    import fib_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  fib_in,
    input  logic             vld_in,
    output logic             rdy_in,
    output logic [OUT_W-1:0] fib_out,
    output logic             vld_out,
    input  logic             rdy_out
);

    state_t           state_q, state_d;
    logic             rdy_in_q, rdy_in_d;
    logic             vld_out_q, vld_out_d;
    logic [OUT_W-1:0] fib_out_q, fib_out_d;
    logic [OUT_W-1:0] core_result;
    logic             core_load, core_step, core_cnt_zero;

    assign core_load = (state_q == IDLE) && rdy_in_q && vld_in;
    assign core_step = (state_q == CALC) && !core_cnt_zero;

    fib_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .n        (fib_in),
        .cnt_zero (core_cnt_zero),
        .result   (core_result)
    );

    always_comb begin
        state_d   = state_q;
        rdy_in_d  = rdy_in_q;
        vld_out_d = vld_out_q;
        fib_out_d = fib_out_q;
        case (state_q)
            IDLE: begin
                if (core_load) begin
                    state_d  = CALC;
                    rdy_in_d = 1'b0;
                end
            end
            CALC: begin
                if (core_cnt_zero) begin
                    state_d   = DONE;
                    vld_out_d = 1'b1;
                    fib_out_d = core_result;
                end
            end
            DONE: begin
                if (rdy_out) begin
                    state_d   = IDLE;
                    vld_out_d = 1'b0;
                    rdy_in_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                vld_out_d = 1'b0;
                rdy_in_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_in_q  <= 1'b1;
            vld_out_q <= 1'b0;
            fib_out_q <= '0;
        end else begin
            state_q   <= state_d;
            rdy_in_q  <= rdy_in_d;
            vld_out_q <= vld_out_d;
            fib_out_q <= fib_out_d;
        end
    end

    assign rdy_in  = rdy_in_q;
    assign vld_out = vld_out_q;
    assign fib_out = fib_out_q;

endmodule

// File: tb/tb_fib.sv
// Directed self-checking bench for fib: reset, small/boundary indices,
// backpressure, busy requests and mid-calculation reset.
module tb_fib;

    logic        clk;
    logic        rst_n;
    logic [7:0]  fib_in;
    logic        vld_in;
    logic        rdy_in;
    logic [31:0] fib_out;
    logic        vld_out;
    logic        rdy_out;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FIB_SATURATE_EN
    localparam logic [31:0] EXP_F48 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_F48 = 32'h1E8D_0A40;
`endif

    fib dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fib_in  (fib_in),
        .vld_in  (vld_in),
        .rdy_in  (rdy_in),
        .fib_out (fib_out),
        .vld_out (vld_out),
        .rdy_out (rdy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] n);
        check("rdy_in_before_req", 32'(rdy_in), 32'd1);
        fib_in = n;
        vld_in = 1'b1;
        tick();
        vld_in = 1'b0;
        check("rdy_in_after_accept", 32'(rdy_in), 32'd0);
    endtask

    // Counts edges after the accept edge until vld_out rises (bounded).
    task automatic wait_done(input bit interfere, output int cyc);
        cyc = 0;
        while (vld_out !== 1'b1 && cyc < 200) begin
            if (interfere) begin
                fib_in = 8'd3;
                vld_in = (cyc >= 2 && cyc < 5);
            end
            tick();
            cyc++;
        end
        vld_in = 1'b0;
    endtask

    task automatic run(input logic [7:0] n, input logic [31:0] exp, input int exp_lat);
        int cyc;
        send(n);
        wait_done(1'b0, cyc);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("result", fib_out, exp);
        tick();
        check("vld_out_cleared", 32'(vld_out), 32'd0);
        check("rdy_in_restored", 32'(rdy_in), 32'd1);
        check("result_retained", fib_out, exp);
    endtask

    initial begin
        int cyc;
        rst_n   = 1'b0;
        vld_in  = 1'b0;
        fib_in  = '0;
        rdy_out = 1'b1;

        repeat (5) tick();
        check("rst_rdy_in", 32'(rdy_in), 32'd1);
        check("rst_vld_out", 32'(vld_out), 32'd0);
        check("rst_fib_out", fib_out, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy_in", 32'(rdy_in), 32'd1);
        check("post_rst_vld_out", 32'(vld_out), 32'd0);
        check("post_rst_fib_out", fib_out, 32'd0);

        run(8'd0, 32'd0, 1);
        run(8'd1, 32'd1, 2);
        run(8'd10, 32'd55, 11);
        run(8'd47, 32'hB119_24E1, 48);
        run(8'd48, EXP_F48, 49);

        // Backpressure: result must hold while rdy_out is low.
        rdy_out = 1'b0;
        send(8'd5);
        wait_done(1'b0, cyc);
        check("bp_latency", 32'(cyc), 32'd6);
        for (int i = 0; i < 10; i++) begin
            check("bp_vld_out_hold", 32'(vld_out), 32'd1);
            check("bp_fib_out_hold", fib_out, 32'd5);
            check("bp_rdy_in_low", 32'(rdy_in), 32'd0);
            tick();
        end
        rdy_out = 1'b1;
        tick();
        check("bp_vld_out_fall", 32'(vld_out), 32'd0);
        check("bp_rdy_in_rise", 32'(rdy_in), 32'd1);

        // A request arriving mid-calculation is dropped, not queued.
        send(8'd20);
        wait_done(1'b1, cyc);
        check("busy_latency", 32'(cyc), 32'd21);
        check("busy_result", fib_out, 32'd6765);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("busy_no_queue_vld", 32'(vld_out), 32'd0);
            check("busy_no_queue_rdy", 32'(rdy_in), 32'd1);
            tick();
        end

        // Reset in the middle of a calculation.
        send(8'd20);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rdy_in", 32'(rdy_in), 32'd1);
        check("midrst_vld_out", 32'(vld_out), 32'd0);
        check("midrst_fib_out", fib_out, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("midrst_no_vld", 32'(vld_out), 32'd0);
        end
        check("midrst_fib_out_idle", fib_out, 32'd0);
        run(8'd3, 32'd2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fib.md
FIB -- requirements
Module: fib

Interface
REQ-001 The module SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter IN_W SHALL default to 8 and set the index width.
REQ-003 Parameter OUT_W SHALL default to 32 and set the result width.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port fib_in: input, IN_W bits, index n of the requested Fibonacci number.
REQ-007 Port vld_in: input, 1 bit, fib_in is valid.
REQ-008 Port rdy_in: output, 1 bit, DUT can accept a request.
REQ-009 Port fib_out: output, OUT_W bits, result F(n).
REQ-010 Port vld_out: output, 1 bit, fib_out is valid.
REQ-011 Port rdy_out: input, 1 bit, downstream accepts the result.

Function
REQ-012 The sequence SHALL be F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
REQ-013 Input handshake SHALL complete on a rising edge where vld_in=1 and rdy_in=1; fib_in is captured on that edge.
REQ-014 The FSM SHALL have three states, IDLE, CALC and DONE; rdy_in=1 only in IDLE, vld_out=1 only in DONE.
REQ-015 The accept edge SHALL load a=0, b=1 and cnt=n, then move to CALC.
REQ-016 In CALC each cycle: if cnt=0, fib_out<=a and go to DONE; else a<=b, b<=a+b, cnt<=cnt-1.
REQ-017 vld_out SHALL rise exactly n+1 clock edges after the accept edge, so F(0) has a latency of 1 cycle.
REQ-018 The sum a+b SHALL be truncated to OUT_W bits, i.e. wrap modulo 2^32 (unless REQ-027 applies).
REQ-019 In DONE, fib_out and vld_out SHALL hold stable until an edge with rdy_out=1.
REQ-020 That edge SHALL clear vld_out and return to IDLE, so rdy_in=1 from the next cycle.
REQ-021 fib_out SHALL retain the last result after the output handshake until a new result is written.
REQ-022 vld_in while busy SHALL be ignored; the request is not queued.
REQ-023 rdy_out SHALL be ignored outside DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, rdy_in=1, vld_out=0, fib_out=0 and a=b=cnt=0.
REQ-025 Reset mid-CALC or mid-DONE SHALL abandon the operation with no output produced.
REQ-026 Outputs SHALL be at their reset values while rst_n=0 and on the first cycle after release.

Configuration
REQ-027 With macro FIB_SATURATE_EN defined, once any intermediate value exceeds 2^OUT_W-1, a sticky flag SHALL make the final fib_out equal all-ones (0xFFFFFFFF).
REQ-028 The sticky flag SHALL be cleared on each accept and on reset.
REQ-029 Without FIB_SATURATE_EN, arithmetic SHALL wrap per REQ-018 and no flag logic SHALL exist.

Structure
REQ-030 Package fib_pkg SHALL hold the default widths and the state enum (IDLE, CALC, DONE).
REQ-031 Sub-module fib_core SHALL hold the a/b/cnt datapath and add/saturate logic; fib SHALL hold the FSM and handshakes.

Verification
REQ-032 Reset: hold rst_n=0 for 5 cycles, release -> rdy_in=1, fib_out=0, vld_out=0.
REQ-033 Small indices, rdy_out=1: n=0 -> 0 after 1 cycle; n=1 -> 1 after 2 cycles; n=10 -> 55 after 11 cycles.
REQ-034 Boundary: n=47 -> 2971215073 (0xB11924E1); n=48 -> 0x1E8D0A40 wrapped, or 0xFFFFFFFF with FIB_SATURATE_EN.
REQ-035 Backpressure: n=5, rdy_out=0 for 10 cycles -> vld_out=1 and fib_out=5 stable, rdy_in=0; rdy_out=1 -> vld_out falls and rdy_in=1 next cycle.
REQ-036 Busy and reset: vld_in with n=3 during CALC of n=20 -> ignored, result 6765; rst_n pulse mid-CALC -> reset values, and no vld_out until the next request.
